// File: rtl/clk_meas_pkg.sv
// Shared definitions for the clock frequency meter: FSM state encoding and
// the gate-timer width helper.
package clk_meas_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        GATE   = 2'd2,
        DONE   = 2'd3
    } meas_state_e;

    // Bits needed for a timer that must hold values 0..cycles.
    function automatic int timer_width(input int cycles);
        return (cycles < 1) ? 1 : $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/clk_freq_meter_if.sv
// Control and result bundle of the frequency meter; the master side starts
// measurements and supplies the compare window, the slave side is the meter.
interface clk_freq_meter_if #(
    parameter int CNT_W = 16
);
    logic             start;
    logic             abort;
    logic [CNT_W-1:0] exp_min;
    logic [CNT_W-1:0] exp_max;
    logic             busy;
    logic [CNT_W-1:0] count;
    logic             valid;
    logic             in_range;
    logic             overflow;

    modport master (
        output start, abort, exp_min, exp_max,
        input  busy, count, valid, in_range, overflow
    );

    modport slave (
        input  start, abort, exp_min, exp_max,
        output busy, count, valid, in_range, overflow
    );
endinterface

// File: rtl/sync_edge_det.sv
// Multi-flop synchroniser for an asynchronous level followed by a rising-edge
// detector; rise is a one-cycle pulse in the clk domain.
module sync_edge_det #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], d};
        prev_d = sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge clk) begin
        // NOTE: synchronous reset -- rst_n is only looked at on the clock edge, so it lives inside the clocked branch, not the sensitivity list.
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments let every stage take its pre-edge neighbour value, which is what makes this a shift chain.
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/clk_freq_meter.sv
// Gated frequency meter: counts synchronised rising edges of sig_in over a
// window of GATE_CYCLES clk cycles and reports count, range and overflow.
module clk_freq_meter
    import clk_meas_pkg::*;
#(
    parameter int GATE_CYCLES = 1000,
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    sig_in,
    clk_freq_meter_if.slave         bus
);

    // One timer serves both the settle wait and the gate window.
    localparam int TMR_SPAN = (GATE_CYCLES > SYNC_STAGES + 1) ? GATE_CYCLES : SYNC_STAGES + 1;
    localparam int TMR_W    = timer_width(TMR_SPAN);

    localparam logic [TMR_W-1:0] GATE_LAST   = TMR_W'(GATE_CYCLES - 1);
    localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SYNC_STAGES);
    localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};

    logic rise;

    sync_edge_det #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge_det (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (sig_in),
        .rise  (rise)
    );

    meas_state_e      state_q,    state_d;
    logic [TMR_W-1:0] tmr_q,      tmr_d;
    logic [CNT_W-1:0] cnt_q,      cnt_d;
    logic             ovf_q,      ovf_d;
    logic [CNT_W-1:0] count_q,    count_d;
    logic             valid_q,    valid_d;
    logic             in_range_q, in_range_d;
    logic             overflow_q, overflow_d;

    always_comb begin
        // NOTE: every signal written here gets a default first; a path that skipped one would infer a latch.
        state_d    = state_q;
        tmr_d      = tmr_q;
        cnt_d      = cnt_q;
        ovf_d      = ovf_q;
        count_d    = count_q;
        valid_d    = 1'b0;
        in_range_d = in_range_q;
        overflow_d = overflow_q;

        unique case (state_q)
            IDLE: begin
                tmr_d = '0;
                cnt_d = '0;
                ovf_d = 1'b0;
                if (bus.start) state_d = SETTLE;
            end
            SETTLE: begin
                if (tmr_q == SETTLE_LAST) begin
                    tmr_d   = '0;
                    state_d = GATE;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            GATE: begin
                if (rise) begin
                    if (cnt_q == CNT_MAX) ovf_d = 1'b1;
                    else                  cnt_d = cnt_q + CNT_W'(1);
                end
                if (tmr_q == GATE_LAST) state_d = DONE;
                else                    tmr_d   = tmr_q + TMR_W'(1);
            end
            DONE: begin
                state_d    = IDLE;
                count_d    = cnt_q;
                overflow_d = ovf_q;
                in_range_d = (bus.exp_min <= cnt_q) && (cnt_q <= bus.exp_max);
                valid_d    = 1'b1;
            end
        endcase

        // Abort wins over start and over publishing a finished window.
        if (bus.abort) begin
            state_d    = IDLE;
            count_d    = count_q;
            overflow_d = overflow_q;
            in_range_d = in_range_q;
            valid_d    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            tmr_q      <= '0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
            count_q    <= '0;
            valid_q    <= 1'b0;
            in_range_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            tmr_q      <= tmr_d;
            cnt_q      <= cnt_d;
            ovf_q      <= ovf_d;
            count_q    <= count_d;
            valid_q    <= valid_d;
            in_range_q <= in_range_d;
            overflow_q <= overflow_d;
        end
    end

    assign bus.busy     = (state_q != IDLE);
    assign bus.count    = count_q;
    assign bus.valid    = valid_q;
    assign bus.in_range = in_range_q;
    assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_clk_freq_meter.sv
// Bench for clk_freq_meter: two instances (wide counter / narrow counter), a
// window-counting reference model checked every cycle, plus literal checks.
module tb_clk_freq_meter;

    localparam int S       = 2;
    localparam int G0      = 1000;
    localparam int G1      = 100;
    localparam int W0      = 16;
    localparam int W1      = 4;
    localparam int MAX_CYC = 20000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n [2];
    logic        sig   [2];
    logic        st    [2];
    logic        ab    [2];
    logic [15:0] mn    [2];
    logic [15:0] mx    [2];
    int          half  [2];
    logic        lvl   [2];
    int          ph    [2];

    int n_cmp  = 0;
    int n_fail = 0;

    clk_freq_meter_if #(.CNT_W(W0)) if0 ();
    clk_freq_meter_if #(.CNT_W(W1)) if1 ();

    assign if0.start   = st[0];
    assign if0.abort   = ab[0];
    assign if0.exp_min = mn[0];
    assign if0.exp_max = mx[0];
    assign if1.start   = st[1];
    assign if1.abort   = ab[1];
    assign if1.exp_min = mn[1][3:0];
    assign if1.exp_max = mx[1][3:0];

    clk_freq_meter #(.GATE_CYCLES(G0), .CNT_W(W0), .SYNC_STAGES(S)) u_dut0 (
        .clk(clk), .rst_n(rst_n[0]), .sig_in(sig[0]), .bus(if0));
    clk_freq_meter #(.GATE_CYCLES(G1), .CNT_W(W1), .SYNC_STAGES(S)) u_dut1 (
        .clk(clk), .rst_n(rst_n[1]), .sig_in(sig[1]), .bus(if1));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40) $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic dut_busy(input int u);
        return (u == 0) ? if0.busy : if1.busy;
    endfunction
    function automatic logic dut_valid(input int u);
        return (u == 0) ? if0.valid : if1.valid;
    endfunction
    function automatic logic dut_inr(input int u);
        return (u == 0) ? if0.in_range : if1.in_range;
    endfunction
    function automatic logic dut_ovf(input int u);
        return (u == 0) ? if0.overflow : if1.overflow;
    endfunction
    function automatic logic [31:0] dut_count(input int u);
        return (u == 0) ? {16'd0, if0.count} : {28'd0, if1.count};
    endfunction

    // Square-wave sources, driven on the falling edge so they are clk-synchronous.
    always @(negedge clk) begin
        for (int u = 0; u < 2; u++) begin
            if (half[u] == 0) begin
                sig[u] = lvl[u];
                ph[u]  = 0;
            end else begin
                ph[u] = ph[u] + 1;
                if (ph[u] >= half[u]) begin
                    ph[u]  = 0;
                    sig[u] = ~sig[u];
                end
            end
        end
    end

    // Reference model: the input as seen at each clk edge, and a measurement
    // timeline expressed as edge offsets from the accepted start.
    int  cyc = 0;
    bit  samp [2][MAX_CYC];
    bit  act  [2];
    int  e0   [2];
    bit  m_busy [2];
    bit  m_valid[2];
    bit  m_inr  [2];
    bit  m_ovf  [2];
    int  m_cnt  [2];

    function automatic int window_edges(input int u, input int first, input int last);
        int n = 0;
        for (int m = first; m <= last; m++)
            if (samp[u][m] && !samp[u][m-1]) n++;
        return n;
    endfunction

    task automatic model_step(input int u);
        int g, maxv, raw;
        g    = (u == 0) ? G0 : G1;
        maxv = (u == 0) ? (1 << W0) - 1 : (1 << W1) - 1;
        samp[u][cyc] = rst_n[u] ? sig[u] : 1'b0;
        if (!rst_n[u]) begin
            for (int k = 1; k <= S; k++) if (cyc - k >= 0) samp[u][cyc-k] = 1'b0;
            act[u] = 0; m_valid[u] = 0; m_cnt[u] = 0; m_inr[u] = 0; m_ovf[u] = 0;
        end else begin
            m_valid[u] = 0;
            if (act[u]) begin
                if (ab[u]) act[u] = 0;
                else if (cyc == e0[u] + S + 2 + g) begin
                    raw        = window_edges(u, e0[u] + 2, e0[u] + g + 1);
                    m_cnt[u]   = (raw > maxv) ? maxv : raw;
                    m_ovf[u]   = (raw > maxv);
                    m_inr[u]   = (int'(mn[u]) & maxv) <= m_cnt[u] && m_cnt[u] <= (int'(mx[u]) & maxv);
                    m_valid[u] = 1;
                    act[u]     = 0;
                end
            end else if (st[u] && !ab[u]) begin
                act[u] = 1;
                e0[u]  = cyc;
            end
        end
        m_busy[u] = act[u];
    endtask

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (cyc < MAX_CYC) begin
            for (int u = 0; u < 2; u++) model_step(u);
            #2;
            for (int u = 0; u < 2; u++) begin
                check($sformatf("u%0d.busy", u),     32'(dut_busy(u)),  32'(m_busy[u]));
                check($sformatf("u%0d.valid", u),    32'(dut_valid(u)), 32'(m_valid[u]));
                check($sformatf("u%0d.count", u),    dut_count(u),      32'(m_cnt[u]));
                check($sformatf("u%0d.in_range", u), 32'(dut_inr(u)),   32'(m_inr[u]));
                check($sformatf("u%0d.overflow", u), 32'(dut_ovf(u)),   32'(m_ovf[u]));
            end
        end
    end

    // Pulse start for one cycle and wait (bounded) for valid; lat counts falling edges.
    task automatic run_meas(input int u, input int budget, output int lat);
        st[u] = 1'b1;
        lat   = 0;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                st[u] = 1'b0;
                check($sformatf("u%0d.busy_after_start", u), 32'(dut_busy(u)), 32'd1);
            end
        end while (!dut_valid(u) && lat < budget);
        check($sformatf("u%0d.valid_seen", u), 32'(dut_valid(u)), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int lat, k;
        bit seen;
        for (int u = 0; u < 2; u++) begin
            rst_n[u] = 1'b0; st[u] = 1'b0; ab[u] = 1'b0; mn[u] = '0; mx[u] = '0;
            half[u] = 0; lvl[u] = 1'b0; sig[u] = 1'b0; ph[u] = 0;
        end
        repeat (3) @(negedge clk);
        check("reset.busy",  32'(if0.busy),  32'd0);
        check("reset.count", 32'(if0.count), 32'd0);
        check("reset.valid", 32'(if1.valid), 32'd0);
        rst_n[0] = 1'b1; rst_n[1] = 1'b1;

        // Toggle every 2 cycles -> 250 edges per 1000-cycle window.
        mn[0] = 16'd249; mx[0] = 16'd251; half[0] = 2;
        repeat (10) @(negedge clk);
        run_meas(0, 1200, lat);
        check("t1.latency",  32'(lat),        32'd1005);
        check("t1.count",    32'(if0.count),  32'd250);
        check("t1.in_range", 32'(if0.in_range), 32'd1);
        check("t1.overflow", 32'(if0.overflow), 32'd0);

        // Toggle every 4 cycles -> 125, outside 200..300.
        mn[0] = 16'd200; mx[0] = 16'd300; half[0] = 4;
        repeat (10) @(negedge clk);
        run_meas(0, 1200, lat);
        check("t2.count",    32'(if0.count),    32'd125);
        check("t2.in_range", 32'(if0.in_range), 32'd0);

        // Narrow counter saturates: 25 edges into a 4-bit counter.
        mn[1] = 16'd0; mx[1] = 16'd15; half[1] = 2;
        repeat (10) @(negedge clk);
        run_meas(1, 300, lat);
        check("t3.latency",  32'(lat),          32'd105);
        check("t3.count",    32'(if1.count),    32'd15);
        check("t3.overflow", 32'(if1.overflow), 32'd1);
        check("t3.in_range", 32'(if1.in_range), 32'd1);

        // Abort 50 cycles into the gate window.
        half[0] = 2;
        st[0] = 1'b1;
        @(negedge clk);
        st[0] = 1'b0;
        repeat (52) @(negedge clk);
        ab[0] = 1'b1;
        @(negedge clk);
        ab[0] = 1'b0;
        check("t4.busy",  32'(if0.busy),  32'd0);
        check("t4.valid", 32'(if0.valid), 32'd0);
        seen = 0;
        repeat (1100) begin
            @(negedge clk);
            if (if0.valid) seen = 1;
        end
        check("t4.no_valid", 32'(seen),      32'd0);
        check("t4.count",    32'(if0.count), 32'd125);

        // Reset mid-gate, then a fresh measurement with a one-value window.
        st[0] = 1'b1;
        @(negedge clk);
        st[0] = 1'b0;
        repeat (100) @(negedge clk);
        rst_n[0] = 1'b0;
        @(negedge clk);
        rst_n[0] = 1'b1;
        check("t5.busy",     32'(if0.busy),     32'd0);
        check("t5.count",    32'(if0.count),    32'd0);
        check("t5.valid",    32'(if0.valid),    32'd0);
        check("t5.in_range", 32'(if0.in_range), 32'd0);
        check("t5.overflow", 32'(if0.overflow), 32'd0);
        mn[0] = 16'd250; mx[0] = 16'd250;
        repeat (5) @(negedge clk);
        run_meas(0, 1200, lat);
        check("t5.count_after", 32'(if0.count),    32'd250);
        check("t5.in_range_eq", 32'(if0.in_range), 32'd1);

        // Inverted bounds never match.
        mn[0] = 16'd251; mx[0] = 16'd249;
        repeat (5) @(negedge clk);
        run_meas(0, 1200, lat);
        check("t6.count",    32'(if0.count),    32'd250);
        check("t6.in_range", 32'(if0.in_range), 32'd0);

        // Constant-high input with start held: back-to-back zero counts.
        half[1] = 0; lvl[1] = 1'b1;
        repeat (10) @(negedge clk);
        run_meas(1, 300, lat);
        st[1] = 1'b1;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!if1.valid && k < 300);
        st[1] = 1'b0;
        check("t7.spacing",  32'(k),            32'd105);
        check("t7.count",    32'(if1.count),    32'd0);
        check("t7.overflow", 32'(if1.overflow), 32'd0);
        repeat (250) @(negedge clk);
        check("t7.idle", 32'(if1.busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
